gate_pwm_ctrl: RTL and testbench

GATE_PWM_CTRL -- requirements
Module: gate_pwm_ctrl

---
 rtl/gate_pwm_pkg.sv | 17 +
 rtl/pwm_counter.sv | 40 ++++
 rtl/gate_pwm_ctrl.sv | 123 ++++++++++++
 tb/tb_gate_pwm_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pwm_pkg.sv
// Shared types and constants for the buck gate PWM controller.
package gate_pwm_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOFT  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  function automatic logic is_active(input state_t s);
    return (s == SOFT) || (s == RUN);
  endfunction

endpackage

// File: rtl/pwm_counter.sv
// PWM period counter: counts 0..period_act-1, flags the terminal count and
// latches the clamped period at each wrap.
module pwm_counter
  import gate_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] period_ld,
  output logic             tc
);

  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0] period_act;

  // Periods below two would leave no room for both an on and an off count.
  assign period_ld = (period < MIN_PERIOD) ? MIN_PERIOD : period;
  assign tc        = (cnt == period_act - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      period_act <= MIN_PERIOD;
    end else if (!run) begin
      cnt <= '0;
    end else if (tc) begin
      cnt        <= '0;
      period_act <= period_ld;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/gate_pwm_ctrl.sv
// Buck gate PWM controller: soft-start / run / fault sequencing, duty shadow
// register with period-boundary update, and registered gate compare.
//
//   state | meaning
//   IDLE  | converter off, counter held at 0, gate low
//   SOFT  | duty ramps by SS_STEP per period up to the commanded duty
//   RUN   | gate on-time equals the active duty command
//   FAULT | tripped; gate low until en is dropped
module gate_pwm_ctrl
  import gate_pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int SS_STEP = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fault,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty_cmd,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             gate,
  output logic             cycle_start,
  output logic [1:0]       state_o
);

  logic [1:0]       rst_sync;
  logic             rst_n;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_ld;
  logic             tc;
  logic             run;
  logic             wrap;
  logic             xfer;
  logic [CNT_W-1:0] duty_act;
  logic [CNT_W-1:0] duty_ld;
  logic [CNT_W-1:0] shadow;
  logic             shadow_full;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] limit_ld;
  logic [CNT_W:0]   limit_sum;
  logic [CNT_W-1:0] on_time;

  // Assert asynchronously, release two clk edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Counter only runs while both this and the next state drive the gate.
  assign run  = is_active(state) && is_active(state_nxt);
  assign wrap = run && tc;

  pwm_counter #(.CNT_W(CNT_W)) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .period    (period),
    .cnt       (cnt),
    .period_ld (period_ld),
    .tc        (tc)
  );

  assign duty_ready = !shadow_full;
  assign xfer       = duty_valid && !shadow_full;
  assign duty_ld    = !shadow_full ? duty_act :
                      (shadow > period_ld) ? period_ld : shadow;

  assign limit_sum = {1'b0, limit} + (CNT_W+1)'(SS_STEP);
  assign limit_ld  = limit_sum[CNT_W] ? '1 : limit_sum[CNT_W-1:0];
  assign on_time   = ((state == SOFT) && (limit < duty_act)) ? limit : duty_act;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && !fault) state_nxt = SOFT;
      SOFT: begin
        if (fault)                             state_nxt = FAULT;
        else if (!en)                          state_nxt = IDLE;
        else if (tc && (limit_ld >= duty_ld))  state_nxt = RUN;
      end
      RUN: begin
        if (fault)    state_nxt = FAULT;
        else if (!en) state_nxt = IDLE;
      end
      FAULT:   if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gate        <= 1'b0;
      cycle_start <= 1'b0;
      duty_act    <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      limit       <= '0;
    end else begin
      state       <= state_nxt;
      gate        <= run && (cnt < on_time);
      cycle_start <= run && (cnt == '0);
      if (wrap) duty_act <= duty_ld;
      // A transfer can only happen while empty, so it never collides with a drain.
      if (xfer) begin
        shadow      <= duty_cmd;
        shadow_full <= 1'b1;
      end else if (wrap) begin
        shadow_full <= 1'b0;
      end
      if (state != SOFT) limit <= '0;
      else if (wrap)     limit <= limit_ld;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_gate_pwm_ctrl.sv
// Directed bench for gate_pwm_ctrl: soft start, duty update, boundaries,
// fault latch and asynchronous reset.
module tb_gate_pwm_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        fault = 1'b0;
  logic [15:0] period = 16'd100;
  logic [15:0] duty_cmd = 16'd0;
  logic        duty_valid = 1'b0;
  logic        duty_ready;
  logic        gate;
  logic        cycle_start;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int per;
    int duty;
    int exp_len;
    int exp_w;
  } vec_t;

  vec_t vecs[8];

  gate_pwm_ctrl #(.CNT_W(16), .SS_STEP(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .fault       (fault),
    .period      (period),
    .duty_cmd    (duty_cmd),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .gate        (gate),
    .cycle_start (cycle_start),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_start(input string name);
    int g = 0;
    while (!cycle_start && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (!cycle_start) begin
      checks++;
      errors++;
      $display("FAIL %s: no cycle_start got 0 expected 1", name);
    end
  endtask

  task automatic wait_state(input string name, input int s);
    int g = 0;
    while (int'(state_o) != s && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check(name, int'(state_o), s);
  endtask

  // Measures one PWM period starting at the current or next cycle_start.
  task automatic measure(output int w, output int len, output int st);
    w = 0;
    len = 0;
    st = -1;
    wait_start("measure_start");
    if (!cycle_start) return;
    st = int'(state_o);
    do begin
      if (gate) w++;
      len++;
      @(negedge clk);
    end while (!cycle_start && len < 1000);
  endtask

  task automatic send_duty(input int v);
    int g = 0;
    while (!duty_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (!duty_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: duty_ready got 0 expected 1");
    end
    duty_cmd   = 16'(v);
    duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
  endtask

  initial begin
    int w, len, st;
    int ss_len[5] = '{2, 100, 100, 100, 100};
    int ss_w[5]   = '{0, 16, 32, 48, 50};
    int ss_st[5]  = '{1, 1, 1, 1, 2};

    vecs[0] = '{100, 0,   100, 0};
    vecs[1] = '{100, 120, 100, 100};
    vecs[2] = '{1,   1,   2,   1};
    vecs[3] = '{10,  10,  10,  10};
    vecs[4] = '{20,  5,   20,  5};
    vecs[5] = '{3,   7,   3,   3};
    vecs[6] = '{0,   2,   2,   2};
    vecs[7] = '{100, 50,  100, 50};

    #22;
    check("rst_state", int'(state_o), 0);
    check("rst_gate", int'(gate), 0);
    check("rst_cycle_start", int'(cycle_start), 0);
    check("rst_duty_ready", int'(duty_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Soft start: command held in the shadow until the first wrap.
    period = 16'd100;
    send_duty(50);
    check("idle_shadow_full", int'(duty_ready), 0);
    check("idle_state", int'(state_o), 0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      measure(w, len, st);
      check($sformatf("ss_len%0d", i), len, ss_len[i]);
      check($sformatf("ss_w%0d", i), w, ss_w[i]);
      check($sformatf("ss_state%0d", i), st, ss_st[i]);
    end
    check("ss_ready_after", int'(duty_ready), 1);

    // Duty update mid-period: index i sits at cnt = i+1.
    wait_start("upd_start");
    w = 0;
    len = 0;
    do begin
      if (gate) w++;
      if (len == 19) begin
        duty_cmd   = 16'd30;
        duty_valid = 1'b1;
      end
      if (len == 20) begin
        duty_valid = 1'b0;
        check("upd_ready_low", int'(duty_ready), 0);
      end
      if (len == 80) check("upd_ready_still_low", int'(duty_ready), 0);
      len++;
      @(negedge clk);
    end while (!cycle_start && len < 1000);
    check("upd_cur_w", w, 50);
    check("upd_ready_after_wrap", int'(duty_ready), 1);
    measure(w, len, st);
    check("upd_next_w", w, 30);

    // Transfer on the wrap edge (cnt==99) applies one period later.
    w = 0;
    len = 0;
    do begin
      if (gate) w++;
      if (len == 98) begin
        duty_cmd   = 16'd70;
        duty_valid = 1'b1;
      end
      if (len == 99) begin
        duty_valid = 1'b0;
        check("coin_ready_low", int'(duty_ready), 0);
      end
      len++;
      @(negedge clk);
    end while (!cycle_start && len < 1000);
    check("coin_cur_w", w, 30);
    measure(w, len, st);
    check("coin_next_w", w, 30);
    measure(w, len, st);
    check("coin_after_w", w, 70);

    for (int i = 0; i < 8; i++) begin
      period = 16'(vecs[i].per);
      send_duty(vecs[i].duty);
      measure(w, len, st);
      measure(w, len, st);
      measure(w, len, st);
      check($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
      check($sformatf("vec%0d_w", i), w, vecs[i].exp_w);
      check($sformatf("vec%0d_state", i), st, 2);
    end

    // Fault at cnt=10 in RUN with duty 50.
    repeat (9) @(negedge clk);
    check("flt_pre_gate", int'(gate), 1);
    fault = 1'b1;
    @(negedge clk);
    check("flt_gate", int'(gate), 0);
    check("flt_state", int'(state_o), 3);
    fault = 1'b0;
    repeat (5) @(negedge clk);
    check("flt_latched", int'(state_o), 3);
    check("flt_latched_gate", int'(gate), 0);
    en = 1'b0;
    @(negedge clk);
    check("flt_to_idle", int'(state_o), 0);

    // Async reset at cnt=25 with gate high.
    en = 1'b1;
    wait_state("rr_run", 2);
    @(negedge clk);
    wait_start("rr_start");
    repeat (24) @(negedge clk);
    check("rr_pre_gate", int'(gate), 1);
    #1 rst = 1'b0;
    #1;
    check("rr_gate", int'(gate), 0);
    check("rr_state", int'(state_o), 0);
    check("rr_cycle_start", int'(cycle_start), 0);
    check("rr_duty_ready", int'(duty_ready), 1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1 check("rel_edge1_state", int'(state_o), 0);
    wait_state("rel_soft", 1);
    measure(w, len, st);
    check("rel_len0", len, 2);
    check("rel_w0", w, 0);
    measure(w, len, st);
    check("rel_len1", len, 100);
    check("rel_w1", w, 0);
    check("rel_state1", st, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
